// File: rtl/multicycle_pkg.sv
// Shared types and encodings for the multicycle MIPS control path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package multicycle_pkg;

    // Controller states; HOLD covers the post-reset settle window before the first fetch.
    typedef enum logic [3:0] {
        S_HOLD,
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXEC,
        S_ALUWB,
        S_BRANCH,
        S_ADDIEX,
        S_ADDIWB,
        S_JUMP,
        S_JAL,
        S_JR
    } state_t;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    // R-type function codes (instr[5:0])
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_JR  = 6'b001000;

    // ALU operation codes
    localparam logic [4:0] ALU_AND = 5'b00000;
    localparam logic [4:0] ALU_OR  = 5'b00001;
    localparam logic [4:0] ALU_ADD = 5'b00010;
    localparam logic [4:0] ALU_SUB = 5'b00110;
    localparam logic [4:0] ALU_SLT = 5'b00111;

    // PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_RD1    = 2'b11;

    // ALU B operand select
    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    // Register-file write data select
    localparam logic [1:0] M2R_ALUOUT = 2'b00;
    localparam logic [1:0] M2R_MDR    = 2'b01;
    localparam logic [1:0] M2R_PC     = 2'b10;

    // Register-file write address select
    localparam logic [1:0] DST_RT = 2'b00;
    localparam logic [1:0] DST_RD = 2'b01;
    localparam logic [1:0] DST_RA = 2'b10;

    // Full set of datapath controls driven by the FSM in one cycle.
    typedef struct packed {
        logic       pc_write;
        logic       iord;
        logic       ir_write;
        logic       mem_write;
        logic [1:0] mem_to_reg;
        logic [1:0] reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [4:0] alu_control;
        logic [1:0] pc_src;
        logic       instr_retired;
        logic       illegal_op;
    } ctrl_t;

    // Successor of DECODE; FETCH here means the instruction could not be decoded.
    function automatic state_t decode_next(input logic [5:0] op,
                                           input logic [5:0] fn,
                                           input logic       fn_valid);
        state_t nxt;
        nxt = S_FETCH;
        case (op)
            OP_LW, OP_SW:   nxt = S_MEMADR;
            OP_RTYPE: begin
                if (fn == FN_JR)
                    nxt = S_JR;
                else if (fn_valid)
                    nxt = S_EXEC;
            end
            OP_BEQ, OP_BNE: nxt = S_BRANCH;
            OP_ADDI:        nxt = S_ADDIEX;
            OP_J:           nxt = S_JUMP;
            OP_JAL:         nxt = S_JAL;
            default:        nxt = S_FETCH;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/alu_func_decode.sv
// Maps an R-type funct field to an ALU operation and flags unsupported codes.
// Latency: purely combinational.
// Backpressure: none.
module alu_func_decode
    import multicycle_pkg::*;
(
    input  logic [5:0] funct,
    output logic [4:0] alu_control,
    output logic       valid
);

    // funct lookup; unknown codes fall back to ADD with valid cleared
    always_comb begin
        alu_control = ALU_ADD;
        valid       = 1'b1;
        case (funct)
            FN_ADD:  alu_control = ALU_ADD;
            FN_SUB:  alu_control = ALU_SUB;
            FN_AND:  alu_control = ALU_AND;
            FN_OR:   alu_control = ALU_OR;
            FN_SLT:  alu_control = ALU_SLT;
            default: valid       = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM sequencing the shared-memory multicycle MIPS datapath.
// Latency: lw 5, sw/R/addi 4, branch/j/jal/jr 3 cycles with memory always ready.
// Backpressure: memReady low stalls FETCH, MEMRD and MEMWR one cycle per low cycle.
module multicycle_controller
    import multicycle_pkg::*;
#(
    parameter int unsigned RESET_PC_HOLD = 1
) (
    input  logic       clock,
    input  logic       resetN,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       memReady,
    output logic       PCWrite,
    output logic       IorD,
    output logic       IRWrite,
    output logic       memWrite,
    output logic [1:0] memToReg,
    output logic [1:0] regDst,
    output logic       regWriteEnable,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [4:0] ALUControl,
    output logic [1:0] PCSrc,
    output logic       instrRetired,
    output logic       illegalOp
);

    localparam logic [3:0] HOLD_INIT = 4'(RESET_PC_HOLD);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] hold_cnt;
    logic [3:0] hold_cnt_nxt;
    ctrl_t      ctrl;
    ctrl_t      ctrl_gated;
    logic [4:0] fn_alu;
    logic       fn_valid;

    alu_func_decode u_func_dec (
        .funct       (funct),
        .alu_control (fn_alu),
        .valid       (fn_valid)
    );

    // State and hold counter registers; reset parks the FSM in HOLD
    always_ff @(posedge clock) begin
        if (!resetN) begin
            state    <= S_HOLD;
            hold_cnt <= HOLD_INIT;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_cnt_nxt;
        end
    end

    // Next-state and per-state control decode
    always_comb begin
        ctrl         = '0;
        state_nxt    = state;
        hold_cnt_nxt = hold_cnt;
        case (state)
            S_HOLD: begin
                // HOLD always lasts at least one cycle, so a count of 0 or 1 both release next edge
                if (hold_cnt != 4'd0)
                    hold_cnt_nxt = hold_cnt - 4'd1;
                if (hold_cnt <= 4'd1)
                    state_nxt = S_FETCH;
            end
            S_FETCH: begin
                ctrl.iord        = 1'b0;
                ctrl.alu_src_a   = 1'b0;
                ctrl.alu_src_b   = SRCB_FOUR;
                ctrl.alu_control = ALU_ADD;
                ctrl.pc_src      = PCSRC_ALU;
                if (memReady) begin
                    ctrl.ir_write = 1'b1;
                    ctrl.pc_write = 1'b1;
                    state_nxt     = S_DECODE;
                end
            end
            S_DECODE: begin
                // Branch target is computed speculatively into ALUOut here
                ctrl.alu_src_a   = 1'b0;
                ctrl.alu_src_b   = SRCB_IMMSH;
                ctrl.alu_control = ALU_ADD;
                state_nxt        = decode_next(opcode, funct, fn_valid);
                ctrl.illegal_op  = (state_nxt == S_FETCH);
            end
            S_MEMADR: begin
                ctrl.alu_src_a   = 1'b1;
                ctrl.alu_src_b   = SRCB_IMM;
                ctrl.alu_control = ALU_ADD;
                state_nxt        = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                ctrl.iord = 1'b1;
                if (memReady)
                    state_nxt = S_MEMWB;
            end
            S_MEMWB: begin
                ctrl.reg_dst       = DST_RT;
                ctrl.mem_to_reg    = M2R_MDR;
                ctrl.reg_write     = 1'b1;
                ctrl.instr_retired = 1'b1;
                state_nxt          = S_FETCH;
            end
            S_MEMWR: begin
                // Write enable stays up through the completing cycle
                ctrl.iord      = 1'b1;
                ctrl.mem_write = 1'b1;
                if (memReady) begin
                    ctrl.instr_retired = 1'b1;
                    state_nxt          = S_FETCH;
                end
            end
            S_EXEC: begin
                ctrl.alu_src_a   = 1'b1;
                ctrl.alu_src_b   = SRCB_B;
                ctrl.alu_control = fn_alu;
                state_nxt        = S_ALUWB;
            end
            S_ALUWB: begin
                ctrl.reg_dst       = DST_RD;
                ctrl.mem_to_reg    = M2R_ALUOUT;
                ctrl.reg_write     = 1'b1;
                ctrl.instr_retired = 1'b1;
                state_nxt          = S_FETCH;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_B;
                ctrl.alu_control   = ALU_SUB;
                ctrl.pc_src        = PCSRC_ALUOUT;
                ctrl.pc_write      = (opcode == OP_BNE) ? ~zero : zero;
                ctrl.instr_retired = 1'b1;
                state_nxt          = S_FETCH;
            end
            S_ADDIEX: begin
                ctrl.alu_src_a   = 1'b1;
                ctrl.alu_src_b   = SRCB_IMM;
                ctrl.alu_control = ALU_ADD;
                state_nxt        = S_ADDIWB;
            end
            S_ADDIWB: begin
                ctrl.reg_dst       = DST_RT;
                ctrl.mem_to_reg    = M2R_ALUOUT;
                ctrl.reg_write     = 1'b1;
                ctrl.instr_retired = 1'b1;
                state_nxt          = S_FETCH;
            end
            S_JUMP: begin
                ctrl.pc_src        = PCSRC_JUMP;
                ctrl.pc_write      = 1'b1;
                ctrl.instr_retired = 1'b1;
                state_nxt          = S_FETCH;
            end
            S_JAL: begin
                // PC still holds PC+4 in this cycle, so it is the link value
                ctrl.reg_dst       = DST_RA;
                ctrl.mem_to_reg    = M2R_PC;
                ctrl.reg_write     = 1'b1;
                ctrl.pc_src        = PCSRC_JUMP;
                ctrl.pc_write      = 1'b1;
                ctrl.instr_retired = 1'b1;
                state_nxt          = S_FETCH;
            end
            S_JR: begin
                ctrl.pc_src        = PCSRC_RD1;
                ctrl.pc_write      = 1'b1;
                ctrl.instr_retired = 1'b1;
                state_nxt          = S_FETCH;
            end
            default: begin
                state_nxt = S_HOLD;
            end
        endcase
    end

    // Reset blanks every control immediately, even before the first clock edge
    assign ctrl_gated = resetN ? ctrl : '0;

    assign PCWrite        = ctrl_gated.pc_write;
    assign IorD           = ctrl_gated.iord;
    assign IRWrite        = ctrl_gated.ir_write;
    assign memWrite       = ctrl_gated.mem_write;
    assign memToReg       = ctrl_gated.mem_to_reg;
    assign regDst         = ctrl_gated.reg_dst;
    assign regWriteEnable = ctrl_gated.reg_write;
    assign ALUSrcA        = ctrl_gated.alu_src_a;
    assign ALUSrcB        = ctrl_gated.alu_src_b;
    assign ALUControl     = ctrl_gated.alu_control;
    assign PCSrc          = ctrl_gated.pc_src;
    assign instrRetired   = ctrl_gated.instr_retired;
    assign illegalOp      = ctrl_gated.illegal_op;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed cases then random instructions.
// Latency: each instruction is checked against the documented cycle counts.
// Backpressure: memReady stalls are injected in fetch and memory phases.
module tb_multicycle_controller;

    logic       clock = 1'b0;
    logic       resetN;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       memReady;
    logic       PCWrite, IorD, IRWrite, memWrite, regWriteEnable, ALUSrcA;
    logic [1:0] memToReg, regDst, ALUSrcB, PCSrc;
    logic [4:0] ALUControl;
    logic       instrRetired, illegalOp;

    int checks = 0;
    int errors = 0;

    // instruction classes used by the reference model
    localparam int C_LW = 0, C_SW = 1, C_R = 2, C_ADDI = 3, C_BEQ = 4;
    localparam int C_BNE = 5, C_J = 6, C_JAL = 7, C_JR = 8, C_ILL = 9;

    always #5 clock = ~clock;

    multicycle_controller #(.RESET_PC_HOLD(1)) dut (
        .clock          (clock),
        .resetN         (resetN),
        .opcode         (opcode),
        .funct          (funct),
        .zero           (zero),
        .memReady       (memReady),
        .PCWrite        (PCWrite),
        .IorD           (IorD),
        .IRWrite        (IRWrite),
        .memWrite       (memWrite),
        .memToReg       (memToReg),
        .regDst         (regDst),
        .regWriteEnable (regWriteEnable),
        .ALUSrcA        (ALUSrcA),
        .ALUSrcB        (ALUSrcB),
        .ALUControl     (ALUControl),
        .PCSrc          (PCSrc),
        .instrRetired   (instrRetired),
        .illegalOp      (illegalOp)
    );

    function automatic logic [20:0] all_outs();
        return {PCWrite, IorD, IRWrite, memWrite, memToReg, regDst, regWriteEnable,
                ALUSrcA, ALUSrcB, ALUControl, PCSrc, instrRetired, illegalOp};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ALU code the spec assigns to each R-type funct
    function automatic logic [4:0] funct_alu(input logic [5:0] fn);
        case (fn)
            6'b100010: return 5'b00110;
            6'b100100: return 5'b00000;
            6'b100101: return 5'b00001;
            6'b101010: return 5'b00111;
            default:   return 5'b00010;
        endcase
    endfunction

    // Run one instruction: fw fetch stalls, mw memory stalls, compare against the model
    task automatic run_instr(input int cls, input logic [5:0] op, input logic [5:0] fn,
                             input logic z, input int fw, input int mw);
        int done = -1;
        int n_ret = 0, n_ill = 0, n_rw = 0, n_mw = 0, n_ir = 0, n_pcw = 0, first_ir = -1;
        int exp_lat, exp_pcw;
        bit mem_op;
        int mstart;
        logic [9:0] snap = '0;
        logic [9:0] exp_snap;
        logic [7:0] ex = '0;
        logic [7:0] exp_ex;
        mem_op = (cls == C_LW) || (cls == C_SW);
        mstart = fw + 3;
        opcode = op;
        funct  = fn;
        zero   = z;
        for (int k = 0; k < 40 && done < 0; k++) begin
            if (k < fw)                                      memReady = 1'b0;
            else if (k == fw)                                memReady = 1'b1;
            else if (mem_op && k >= mstart && k < mstart+mw) memReady = 1'b0;
            else if (mem_op && k == mstart + mw)             memReady = 1'b1;
            else                                             memReady = 1'($urandom_range(0, 1));
            @(negedge clock);
            n_ret += int'(instrRetired);
            n_ill += int'(illegalOp);
            n_rw  += int'(regWriteEnable);
            n_mw  += int'(memWrite);
            n_pcw += int'(PCWrite);
            if (IRWrite) begin
                n_ir++;
                if (first_ir < 0) first_ir = k;
            end
            if (k == fw)
                check("fetch_sel", {IorD, ALUSrcA, ALUSrcB, ALUControl, PCSrc},
                      {1'b0, 1'b0, 2'b01, 5'b00010, 2'b00});
            if (k == fw + 2)
                ex = {ALUSrcA, ALUSrcB, ALUControl};
            if (instrRetired || illegalOp) begin
                done = k;
                snap = {regDst, memToReg, PCSrc, regWriteEnable, PCWrite, IorD, memWrite};
            end
            @(posedge clock);
            #1;
        end
        if (done < 0) begin
            check("timeout", 32'd0, 32'd1);
            return;
        end
        case (cls)
            C_LW:    exp_lat = 5;
            C_SW, C_R, C_ADDI: exp_lat = 4;
            C_ILL:   exp_lat = 2;
            default: exp_lat = 3;
        endcase
        if (mem_op) exp_lat += mw;
        exp_lat += fw;
        exp_pcw = 1;
        if (cls == C_J || cls == C_JAL || cls == C_JR) exp_pcw++;
        if ((cls == C_BEQ && z) || (cls == C_BNE && !z)) exp_pcw++;
        case (cls)
            C_LW:    exp_snap = {2'b00, 2'b01, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0};
            C_SW:    exp_snap = {2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1};
            C_R:     exp_snap = {2'b01, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0};
            C_ADDI:  exp_snap = {2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0};
            C_BEQ:   exp_snap = {2'b00, 2'b00, 2'b01, 1'b0, z,    1'b0, 1'b0};
            C_BNE:   exp_snap = {2'b00, 2'b00, 2'b01, 1'b0, ~z,   1'b0, 1'b0};
            C_J:     exp_snap = {2'b00, 2'b00, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0};
            C_JAL:   exp_snap = {2'b10, 2'b10, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0};
            C_JR:    exp_snap = {2'b00, 2'b00, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0};
            default: exp_snap = '0;
        endcase
        check("latency",   32'(done + 1), 32'(exp_lat));
        check("fetch_at",  32'(first_ir), 32'(fw));
        check("irwrite_n", 32'(n_ir), 32'd1);
        check("retired_n", 32'(n_ret), (cls == C_ILL) ? 32'd0 : 32'd1);
        check("illegal_n", 32'(n_ill), (cls == C_ILL) ? 32'd1 : 32'd0);
        check("regwr_n",   32'(n_rw),
              (cls == C_LW || cls == C_R || cls == C_ADDI || cls == C_JAL) ? 32'd1 : 32'd0);
        check("memwr_n",   32'(n_mw), (cls == C_SW) ? 32'(mw + 1) : 32'd0);
        check("pcwrite_n", 32'(n_pcw), 32'(exp_pcw));
        check("final_sel", 32'(snap), 32'(exp_snap));
        exp_ex = 'x;
        if (cls == C_LW || cls == C_SW || cls == C_ADDI) exp_ex = {1'b1, 2'b10, 5'b00010};
        if (cls == C_R)                                  exp_ex = {1'b1, 2'b00, funct_alu(fn)};
        if (cls == C_BEQ || cls == C_BNE)                exp_ex = {1'b1, 2'b00, 5'b00110};
        if (!$isunknown(exp_ex))
            check("exec_alu", 32'(ex), 32'(exp_ex));
    endtask

    logic [5:0] rfns [5];
    int         rw_abort;

    initial begin
        rfns[0] = 6'b100000; rfns[1] = 6'b100010; rfns[2] = 6'b100100;
        rfns[3] = 6'b100101; rfns[4] = 6'b101010;
        resetN   = 1'b0;
        memReady = 1'b1;
        opcode   = 6'b000010;
        funct    = 6'b000000;
        zero     = 1'b0;

        // reset held three cycles: everything low
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("reset_outs", 32'(all_outs()), 32'd0);
            @(posedge clock);
            #1;
        end
        resetN = 1'b1;
        @(negedge clock);
        check("hold_enables", {PCWrite, IRWrite, memWrite, regWriteEnable}, 4'b0000);
        @(posedge clock);
        #1;
        // first fetch must accept immediately on the 2nd cycle after release
        run_instr(C_J, 6'b000010, 6'b000000, 1'b0, 0, 0);

        // directed cases
        run_instr(C_LW,  6'b100011, 6'b000000, 1'b0, 0, 0);
        run_instr(C_SW,  6'b101011, 6'b000000, 1'b0, 0, 2);
        run_instr(C_BEQ, 6'b000100, 6'b000000, 1'b1, 0, 0);
        run_instr(C_BNE, 6'b000101, 6'b000000, 1'b1, 0, 0);
        run_instr(C_JAL, 6'b000011, 6'b000000, 1'b0, 0, 0);
        run_instr(C_JR,  6'b000000, 6'b001000, 1'b0, 0, 0);
        run_instr(C_ILL, 6'b111111, 6'b000000, 1'b0, 0, 0);
        run_instr(C_ILL, 6'b000000, 6'b000001, 1'b0, 1, 0);
        run_instr(C_R,   6'b000000, 6'b101010, 1'b0, 2, 0);
        run_instr(C_ADDI,6'b001000, 6'b000000, 1'b0, 0, 0);

        // lw aborted by reset while waiting in the memory read
        rw_abort = 0;
        opcode   = 6'b100011;
        funct    = 6'b000000;
        for (int k = 0; k < 4; k++) begin
            memReady = (k == 0) ? 1'b1 : 1'b0;
            @(negedge clock);
            rw_abort += int'(regWriteEnable);
            if (k == 3) check("abort_memrd_iord", 32'(IorD), 32'd1);
            @(posedge clock);
            #1;
        end
        resetN = 1'b0;
        for (int k = 0; k < 2; k++) begin
            memReady = 1'b1;
            @(negedge clock);
            rw_abort += int'(regWriteEnable);
            check("abort_outs", 32'(all_outs()), 32'd0);
            @(posedge clock);
            #1;
        end
        resetN = 1'b1;
        @(negedge clock);
        rw_abort += int'(regWriteEnable);
        check("abort_hold", {PCWrite, IRWrite, memWrite, regWriteEnable}, 4'b0000);
        check("abort_regwr", 32'(rw_abort), 32'd0);
        @(posedge clock);
        #1;
        run_instr(C_LW, 6'b100011, 6'b000000, 1'b0, 0, 1);

        // randomized instruction stream
        for (int n = 0; n < 40; n++) begin
            int         cls;
            logic [5:0] op, fn;
            cls = int'($urandom_range(0, 9));
            fn  = 6'(rfns[$urandom_range(0, 4)]);
            case (cls)
                C_LW:    op = 6'b100011;
                C_SW:    op = 6'b101011;
                C_R:     op = 6'b000000;
                C_ADDI:  op = 6'b001000;
                C_BEQ:   op = 6'b000100;
                C_BNE:   op = 6'b000101;
                C_J:     op = 6'b000010;
                C_JAL:   op = 6'b000011;
                C_JR:    begin op = 6'b000000; fn = 6'b001000; end
                default: begin
                    if ($urandom_range(0, 1) == 0) op = 6'b111110;
                    else begin op = 6'b000000; fn = 6'b000011; end
                end
            endcase
            run_instr(cls, op, fn, 1'($urandom_range(0, 1)),
                      int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
